filter_coeff_ramp: RTL
======================

// Module: filter_coeff_ramp
// PURPOSE
//   Drives the cutoff and gain coefficient inputs of the first-order low-pass filter stage.
//   Accepts a target coefficient pair via valid/ready and slews the live outputs toward it.
//   Each coefficient moves by at most step_i per update; updates occur every div_i+1 clocks.
//   This prevents filter-state transients when feedback parameters are retuned at runtime.
// PARAMETERS
//   WIDTH      16  coefficient width; same as the filter's WIDTH; values are unsigned magnitudes
//   STEP_W     16  width of step_i
//   DIV_W      16  width of the update-interval prescaler div_i
//   RST_CUTOFF 0   cutoff_o value in reset
//   RST_GAIN   0   gain_o value in reset
// PORTS
//   clk_i        in   1       clock
//   rst_ni       in   1       reset, asynchronous, active-low
//   tgt_cutoff_i in   WIDTH   target cutoff; sampled on accept
//   tgt_gain_i   in   WIDTH   target gain; sampled on accept
//   step_i       in   STEP_W  maximum change per update; sampled on accept
//   div_i        in   DIV_W   update interval minus 1; sampled on accept
//   tgt_valid_i  in   1       target request
//   tgt_ready_o  out  1       high in IDLE only; accept = tgt_valid_i & tgt_ready_o
//   abort_i      in   1       stop ramp and freeze outputs
//   cutoff_o     out  WIDTH   live cutoff coefficient, registered; connects to filter cutoff_i
//   gain_o       out  WIDTH   live gain coefficient, registered; connects to filter gain_i
//   busy_o       out  1       high in RAMP and DONE
//   upd_o        out  1       1-cycle pulse on the cycle after an update edge
//   done_o       out  1       1-cycle pulse when both coefficients reach their targets
// BEHAVIOUR
//   Reset values
//     cutoff_o=RST_CUTOFF, gain_o=RST_GAIN; state IDLE; tgt_ready_o=1; busy_o=upd_o=done_o=0.
//     Reset mid-ramp takes effect immediately (asynchronous); the ramp is lost.
//   FSM states: IDLE, RAMP, DONE
//     IDLE -> RAMP on accept; latch targets, step and div; load prescaler with div.
//     IDLE -> DONE on accept when both targets already equal the live outputs.
//     RAMP: prescaler decrements each cycle. At 0: apply the update, reload with div, pulse upd_o.
//       The update edge that makes both outputs equal their targets goes to DONE.
//     DONE -> IDLE after 1 cycle with done_o=1; tgt_ready_o=1 again the following cycle.
//     abort_i in RAMP -> IDLE on the next edge; outputs hold; no update that edge; no done_o.
//     abort_i outside RAMP has no effect; tgt_valid_i while not ready is ignored (no queueing).
//   Timing: accept edge = E0; updates on edges E0+(div+1)*k, k>=1; div=0 updates every clock.
//   Update rule, per coefficient, independent
//     If |tgt-cur| <= step then cur=tgt, else cur = cur +/- step toward tgt.
//     Compare in max(WIDTH,STEP_W)+1 bits unsigned; never wraps; never overshoots.
//     A coefficient already at target holds while the other continues.
//   step_i==0 behaves as step 1, so a ramp always terminates.
//   Outputs change only on update edges; both coefficients change on the same edge.
// STRUCTURE
//   Shared include filt_defs.vh: FSM state localparams (IDLE=2'd0, RAMP=2'd1, DONE=2'd2).
//   Sub-module coeff_slew: combinational next = slew(cur, tgt, step) plus at_tgt flag.
//   coeff_slew is instantiated twice, once for cutoff and once for gain.
//   Top level holds the FSM, prescaler, latched targets and output registers.
// TESTING
//   1 Reset: hold rst_ni=0 -> cutoff_o=0, gain_o=0, tgt_ready_o=1, busy_o=0; release: no change.
//   2 Upward ramp: cutoff 0->100, gain 0->0, step=30, div=0
//       cutoff_o 30,60,90,100 on consecutive edges; done_o the cycle after 100; ready one cycle later.
//   3 Downward ramp: from cutoff 100, target 5, step=40, div=2 -> cutoff_o 60,20,5, updates 3 clocks apart.
//   4 Unequal distances: cutoff 0->10, gain 0->100, step=50
//       cutoff 10 then holds; gain 50 then 100; done_o after gain reaches 100.
//   5 Abort / busy: abort_i after first update -> value frozen, no done_o, ready next cycle
//       tgt_valid_i during RAMP -> ignored.
//   6 Corners
//       step=0, target +3 -> +1 per update (3 updates).
//       0->65535 with step=65535 -> one update, no wrap.
//       Target equal to current -> done_o without upd_o.

Source files
------------

// File: rtl/filter_coeff_ramp_pkg.sv
// Shared types and helpers for the coefficient slew controller.
// The state encodings line up with the values used elsewhere in the filter codebase.
package filter_coeff_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } ramp_state_e;

  // Distance comparisons need one bit above the wider operand so they never wrap.
  function automatic int unsigned cmp_width(input int unsigned a, input int unsigned b);
    return ((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/filter_coeff_ramp_if.sv
// Target request, control and live coefficient bundle for filter_coeff_ramp.
// The master side issues targets and consumes the coefficients; the slave side is the ramp.
interface filter_coeff_ramp_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned DIV_W  = 16
) ();

  logic [WIDTH-1:0]  tgt_cutoff_i;
  logic [WIDTH-1:0]  tgt_gain_i;
  logic [STEP_W-1:0] step_i;
  logic [DIV_W-1:0]  div_i;
  logic              tgt_valid_i;
  logic              tgt_ready_o;
  logic              abort_i;
  logic [WIDTH-1:0]  cutoff_o;
  logic [WIDTH-1:0]  gain_o;
  logic              busy_o;
  logic              upd_o;
  logic              done_o;

  modport master (
    output tgt_cutoff_i, tgt_gain_i, step_i, div_i, tgt_valid_i, abort_i,
    input  tgt_ready_o, cutoff_o, gain_o, busy_o, upd_o, done_o
  );

  modport slave (
    input  tgt_cutoff_i, tgt_gain_i, step_i, div_i, tgt_valid_i, abort_i,
    output tgt_ready_o, cutoff_o, gain_o, busy_o, upd_o, done_o
  );

endinterface

// File: rtl/filter_coeff_ramp_coeff_slew.sv
// One slew step for a single coefficient: moves cur toward tgt by at most step.
// at_tgt_o reports that the proposed next value lands exactly on the target.
module coeff_slew
  import filter_coeff_ramp_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 16
) (
  input  logic [WIDTH-1:0]  cur_i,
  input  logic [WIDTH-1:0]  tgt_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [WIDTH-1:0]  nxt_o,
  output logic              at_tgt_o
);

  localparam int unsigned CW = cmp_width(WIDTH, STEP_W);

  logic [CW-1:0] cur_w;
  logic [CW-1:0] tgt_w;
  logic [CW-1:0] step_w;
  logic [CW-1:0] dist_w;
  logic [CW-1:0] nxt_w;
  logic          up;

  // Snapping to the target when it is within reach is what prevents overshoot.
  always_comb begin
    cur_w  = CW'(cur_i);
    tgt_w  = CW'(tgt_i);
    step_w = CW'(step_i);
    up     = (tgt_w >= cur_w);
    dist_w = up ? (tgt_w - cur_w) : (cur_w - tgt_w);
    if (dist_w <= step_w) begin
      nxt_w = tgt_w;
    end else if (up) begin
      nxt_w = cur_w + step_w;
    end else begin
      nxt_w = cur_w - step_w;
    end
  end

  assign nxt_o    = nxt_w[WIDTH-1:0];
  assign at_tgt_o = (nxt_w == tgt_w);

endmodule

// File: rtl/filter_coeff_ramp.sv
// Slews the filter cutoff/gain coefficients toward an accepted target pair,
// one bounded step every div+1 clocks, so runtime retuning never jolts the filter state.
module filter_coeff_ramp
  import filter_coeff_ramp_pkg::*;
#(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      STEP_W     = 16,
  parameter int unsigned      DIV_W      = 16,
  parameter logic [WIDTH-1:0] RST_CUTOFF = '0,
  parameter logic [WIDTH-1:0] RST_GAIN   = '0
) (
  input logic                clk_i,
  input logic                rst_ni,
  filter_coeff_ramp_if.slave bus
);

  ramp_state_e       state_q, state_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  tgt_cutoff_q, tgt_cutoff_d;
  logic [WIDTH-1:0]  tgt_gain_q, tgt_gain_d;
  logic [WIDTH-1:0]  cutoff_q, cutoff_d;
  logic [WIDTH-1:0]  gain_q, gain_d;
  logic              upd_q, upd_d;

  logic [WIDTH-1:0]  cutoff_nxt;
  logic [WIDTH-1:0]  gain_nxt;
  logic              cutoff_at_tgt;
  logic              gain_at_tgt;
  logic              accept;

  coeff_slew #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_cutoff_slew (
    .cur_i    (cutoff_q),
    .tgt_i    (tgt_cutoff_q),
    .step_i   (step_q),
    .nxt_o    (cutoff_nxt),
    .at_tgt_o (cutoff_at_tgt)
  );

  coeff_slew #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_gain_slew (
    .cur_i    (gain_q),
    .tgt_i    (tgt_gain_q),
    .step_i   (step_q),
    .nxt_o    (gain_nxt),
    .at_tgt_o (gain_at_tgt)
  );

  assign accept = bus.tgt_valid_i && (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    div_d        = div_q;
    step_d       = step_q;
    tgt_cutoff_d = tgt_cutoff_q;
    tgt_gain_d   = tgt_gain_q;
    cutoff_d     = cutoff_q;
    gain_d       = gain_q;
    upd_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_cutoff_d = bus.tgt_cutoff_i;
          tgt_gain_d   = bus.tgt_gain_i;
          div_d        = bus.div_i;
          presc_d      = bus.div_i;
          // A zero step would never converge, so it is promoted to one.
          step_d       = (bus.step_i == '0) ? STEP_W'(1) : bus.step_i;
          if ((bus.tgt_cutoff_i == cutoff_q) && (bus.tgt_gain_i == gain_q)) begin
            state_d = DONE;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (presc_q == '0) begin
          cutoff_d = cutoff_nxt;
          gain_d   = gain_nxt;
          upd_d    = 1'b1;
          presc_d  = div_q;
          if (cutoff_at_tgt && gain_at_tgt) begin
            state_d = DONE;
          end
        end else begin
          presc_d = presc_q - DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      div_q        <= '0;
      step_q       <= STEP_W'(1);
      tgt_cutoff_q <= RST_CUTOFF;
      tgt_gain_q   <= RST_GAIN;
      cutoff_q     <= RST_CUTOFF;
      gain_q       <= RST_GAIN;
      upd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      div_q        <= div_d;
      step_q       <= step_d;
      tgt_cutoff_q <= tgt_cutoff_d;
      tgt_gain_q   <= tgt_gain_d;
      cutoff_q     <= cutoff_d;
      gain_q       <= gain_d;
      upd_q        <= upd_d;
    end
  end

  assign bus.tgt_ready_o = (state_q == IDLE);
  assign bus.busy_o      = (state_q == RAMP) || (state_q == DONE);
  assign bus.done_o      = (state_q == DONE);
  assign bus.upd_o       = upd_q;
  assign bus.cutoff_o    = cutoff_q;
  assign bus.gain_o      = gain_q;

endmodule
